// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate type used by the
// timing generator and the sprite drawing stages.
package vga_timing_pkg;

  localparam int H_VIS        = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS        = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // hs/vs lag behind DrawX/DrawY by this many cycles to line up with the
  // registered colour output of the drawing stages.
  localparam int SYNC_DLY     = 1;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Reset-to-one shift register that delays the active-low sync pair so it
// leaves the block alongside the pixel pipeline's colour output.
module vga_sync_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Idle sync level is high, so every stage resets to one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= {WIDTH{1'b1}};
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered blank, delayed
// hs/vs, and a per-frame tick with an 8-bit frame counter for game logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_VIS,
  parameter int H_FRONT    = H_FP,
  parameter int H_SYNC_W   = H_SYNC,
  parameter int H_BACK     = H_BP,
  parameter int V_ACTIVE   = V_VIS,
  parameter int V_FRONT    = V_FP,
  parameter int V_SYNC_W   = V_SYNC,
  parameter int V_BACK     = V_BP,
  parameter int SYNC_DELAY = SYNC_DLY
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam coord_t X_LAST = coord_t'(H_ACTIVE + H_FRONT + H_SYNC_W + H_BACK - 1);
  localparam coord_t X_VIS  = coord_t'(H_ACTIVE);
  localparam coord_t X_SS   = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t X_SE   = coord_t'(H_ACTIVE + H_FRONT + H_SYNC_W);
  localparam coord_t Y_LAST = coord_t'(V_ACTIVE + V_FRONT + V_SYNC_W + V_BACK - 1);
  localparam coord_t Y_VIS  = coord_t'(V_ACTIVE);
  localparam coord_t Y_SS   = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t Y_SE   = coord_t'(V_ACTIVE + V_FRONT + V_SYNC_W);

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       blank_q, blank_d;
  logic       tick_q, tick_d;
  logic [7:0] count_q, count_d;
  logic       hsync_raw, vsync_raw;
  logic [1:0] sync_dly;

  // blank and tick are derived from the next coordinates so that, once
  // registered, they line up exactly with DrawX/DrawY.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    blank_d = 1'b0;
    tick_d  = 1'b0;
    count_d = count_q;
    if (x_q == X_LAST) begin
      x_d = 10'd0;
      if (y_q == Y_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
    end
    blank_d = (x_d < X_VIS) && (y_d < Y_VIS);
    tick_d  = (x_d == 10'd0) && (y_d == Y_VIS);
    if (tick_d) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= X_LAST;
      y_q     <= Y_LAST;
      blank_q <= 1'b0;
      tick_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

  assign hsync_raw = ~((x_q >= X_SS) && (x_q < X_SE));
  assign vsync_raw = ~((y_q >= Y_SS) && (y_q < Y_SE));

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({vsync_raw, hsync_raw}),
    .dout  (sync_dly)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = sync_dly[0];
  assign vs          = sync_dly[1];
  assign frame_tick  = tick_q;
  assign frame_count = count_q;

endmodule
